// File: rtl/tea_pkg.sv
// rtl/tea_pkg.sv - TEA constants and state encoding shared by encrypt, decrypt and key sweeper
package tea_pkg;

  localparam logic [31:0] DELTA         = 32'h9E37_79B9;
  localparam logic [31:0] DECRYPT_SUM_0 = 32'hC6EF_3720;
  localparam int          CNT_W         = 5;

  localparam logic [31:0]  PDF_PLAIN_HEADER_1 = 32'h2550_4446;
  localparam logic [31:0]  PDF_PLAIN_HEADER_2 = 32'h2D31_2E36;
  localparam logic [63:0]  PDF_PLAIN_HEADER   = {PDF_PLAIN_HEADER_1, PDF_PLAIN_HEADER_2};
  localparam logic [127:0] KEY = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Full 32-cycle encryption; used here only to derive the encrypted header constant.
  function automatic logic [63:0] tea_encrypt(input logic [63:0] blk, input logic [127:0] k);
    logic [31:0] v0;
    logic [31:0] v1;
    logic [31:0] s;
    v0 = blk[31:0];
    v1 = blk[63:32];
    s  = '0;
    for (int i = 0; i < 32; i++) begin
      s  = s + DELTA;
      v0 = v0 + (((v1 << 4) + k[127:96]) ^ (v1 + s) ^ ((v1 >> 5) + k[95:64]));
      v1 = v1 + (((v0 << 4) + k[63:32]) ^ (v0 + s) ^ ((v0 >> 5) + k[31:0]));
    end
    return {v1, v0};
  endfunction

  localparam logic [63:0] PDF_ENCRYPTED_HEADER   = tea_encrypt(PDF_PLAIN_HEADER, KEY);
  localparam logic [31:0] PDF_ENCRYPTED_HEADER_1 = PDF_ENCRYPTED_HEADER[63:32];
  localparam logic [31:0] PDF_ENCRYPTED_HEADER_2 = PDF_ENCRYPTED_HEADER[31:0];

endpackage

// File: rtl/tea_dec_round.sv
// rtl/tea_dec_round.sv - one combinational TEA decryption cycle
module tea_dec_round
  import tea_pkg::*;
(
  input  logic [31:0]  v0,
  input  logic [31:0]  v1,
  input  logic [31:0]  sum,
  input  logic [127:0] key,
  output logic [31:0]  v0_nxt,
  output logic [31:0]  v1_nxt
);

  // v0 half uses the already-updated v1, undoing the encrypt order.
  assign v1_nxt = v1 - (((v0 << 4) + key[63:32]) ^ (v0 + sum) ^ ((v0 >> 5) + key[31:0]));
  assign v0_nxt = v0 - (((v1_nxt << 4) + key[127:96]) ^ (v1_nxt + sum) ^ ((v1_nxt >> 5) + key[95:64]));

endmodule

// File: rtl/tea_decrypt_iter.sv
// rtl/tea_decrypt_iter.sv - iterative TEA block decryptor, one cycle per clock, PDF header flag
module tea_decrypt_iter
  import tea_pkg::*;
#(
  parameter int ROUNDS = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [63:0]  inBlock64,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  outBlock64,
  output logic         hdr_match
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(ROUNDS - 1);

  state_t             state;
  logic [31:0]        v0;
  logic [31:0]        v1;
  logic [31:0]        sum;
  logic [127:0]       k;
  logic [CNT_W-1:0]   cnt;
  logic [31:0]        v0_nxt;
  logic [31:0]        v1_nxt;

  tea_dec_round u_round (
    .v0     (v0),
    .v1     (v1),
    .sum    (sum),
    .key    (k),
    .v0_nxt (v0_nxt),
    .v1_nxt (v1_nxt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      outBlock64 <= '0;
      hdr_match  <= 1'b0;
      cnt        <= '0;
      sum        <= '0;
      v0         <= '0;
      v1         <= '0;
      k          <= '0;
    end else if (ena) begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            v0       <= inBlock64[31:0];
            v1       <= inBlock64[63:32];
            k        <= key;
            sum      <= DECRYPT_SUM_0;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          v0  <= v0_nxt;
          v1  <= v1_nxt;
          sum <= sum - DELTA;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            // A full-length schedule must unwind the sum exactly to zero.
            if (ROUNDS == 32) assert (sum - DELTA == 32'd0);
            outBlock64 <= {v1_nxt, v0_nxt};
            hdr_match  <= ({v1_nxt, v0_nxt} == PDF_PLAIN_HEADER);
            out_valid  <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tea_decrypt_iter.sv
// tb/tb_tea_decrypt_iter.sv - directed and randomized checks of tea_decrypt_iter
module tb_tea_decrypt_iter;
  import tea_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         ena = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [63:0]  inBlock64 = '0;
  logic [127:0] key = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [63:0]  outBlock64;
  logic         hdr_match;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int acc = 0;
  int prev_acc = 0;
  int g;
  logic [63:0]  p;
  logic [127:0] kk;

  localparam logic [63:0] HDR_PLAIN = 64'h2550_4446_2D31_2E36;
  localparam logic [63:0] ZK_CT     = {32'h94BA_A940, 32'h41EA_3A0A};

  tea_decrypt_iter dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .inBlock64  (inBlock64),
    .key        (key),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .outBlock64 (outBlock64),
    .hdr_match  (hdr_match)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] model_enc(input logic [63:0] blk, input logic [127:0] k);
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] s;
    a = blk[31:0];
    b = blk[63:32];
    s = 32'd0;
    for (int i = 0; i < 32; i++) begin
      s = s + 32'h9E37_79B9;
      a = a + (((b << 4) + k[127:96]) ^ (b + s) ^ ((b >> 5) + k[95:64]));
      b = b + (((a << 4) + k[63:32]) ^ (a + s) ^ ((a >> 5) + k[31:0]));
    end
    return {b, a};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic accept(input logic [63:0] blk, input logic [127:0] k);
    @(negedge clk);
    inBlock64 = blk;
    key       = k;
    in_valid  = 1'b1;
    for (int i = 0; i < 100 && !in_ready; i++) @(negedge clk);
    check("in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    acc       = cyc;
    in_valid  = 1'b0;
    inBlock64 = ~blk;
    key       = ~k;
  endtask

  task automatic wait_out(input string tag, input logic [63:0] exp_blk, input logic exp_hdr,
                          input int exp_lat);
    int lat;
    for (int i = 0; i < 100 && !out_valid; i++) @(negedge clk);
    lat = cyc - acc;
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_data"}, outBlock64, exp_blk);
    check({tag, "_hdr"}, 64'(hdr_match), 64'(exp_hdr));
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out", outBlock64, 64'd0);
    check("rst_hdr", 64'(hdr_match), 64'd0);
    check("rst_cnt", 64'(dut.cnt), 64'd0);
    check("rst_sum", 64'(dut.sum), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // zero-key vector
    accept(ZK_CT, 128'd0);
    wait_out("zero", 64'd0, 1'b0, 32);
    @(posedge clk);
    @(negedge clk);
    check("zero_idle_ready", 64'(in_ready), 64'd1);

    // header vector held under back-pressure, with in_valid pulses ignored
    out_ready = 1'b0;
    accept({PDF_ENCRYPTED_HEADER_1, PDF_ENCRYPTED_HEADER_2}, KEY);
    wait_out("hdr", HDR_PLAIN, 1'b1, 32);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      @(negedge clk);
      check("bp_data", outBlock64, HDR_PLAIN);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_valid", 64'(out_valid), 64'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_rel_ready", 64'(in_ready), 64'd1);
    check("bp_rel_valid", 64'(out_valid), 64'd0);

    // asynchronous reset in the middle of a block
    accept(ZK_CT, 128'd0);
    repeat (17) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_out", outBlock64, 64'd0);
    check("mid_rst_hdr", 64'(hdr_match), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    accept({PDF_ENCRYPTED_HEADER_1, PDF_ENCRYPTED_HEADER_2}, KEY);
    wait_out("post_rst", HDR_PLAIN, 1'b1, 32);
    @(posedge clk);

    // five single-cycle enable gaps during RUN
    accept(ZK_CT, 128'd0);
    g = $urandom_range(1, 20);
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      ena = !(k >= g && k < g + 10 && ((k - g) % 2 == 0));
    end
    ena = 1'b1;
    wait_out("ena_gap", 64'd0, 1'b0, 37);
    @(posedge clk);

    // back-to-back random blocks encrypted by the model
    for (int n = 0; n < 1000; n++) begin
      p  = {$urandom, $urandom};
      kk = {$urandom, $urandom, $urandom, $urandom};
      accept(model_enc(p, kk), kk);
      if (n > 0) check("b2b_spacing", 64'(acc - prev_acc), 64'd34);
      prev_acc = acc;
      wait_out("rand", p, p == HDR_PLAIN, 32);
      @(posedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
